// File: rtl/load_store_unit.sv
// load_store_unit: runs LOAD/STORE accesses on a word-addressed req/ready bus and handles byte-lane steering and load extension.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two bus transactions instead of rejecting them.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  op_code,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_value,
  output logic        misaligned,
  output logic        bus_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t state_q, state_d;

  logic        we_q, uns_q, mis_q, to_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] word_addr_q, rdata_lo_q, load_value_q, wait_cnt;
  logic [7:0]  mask_q;
  logic [63:0] data_q;

  logic        is_load, is_store, legal, misal, second, timeout_hit;
  logic [1:0]  off, size;
  logic [3:0]  base_strb;
  logic [7:0]  mask_in;
  logic [63:0] lane_be, data_in, merged;

  assign off  = address[1:0];
  assign size = funct3[1:0];

  // Lane mask and data span 8 bytes so a word-crossing access splits into low/high words.
  always_comb begin
    is_load  = (op_code == OP_LOAD) && (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
    is_store = (op_code == OP_STORE) && (funct3 <= 3'd2);
    legal    = is_load || is_store;
    case (size)
      2'd0:    base_strb = 4'b0001;
      2'd1:    base_strb = 4'b0011;
      default: base_strb = 4'b1111;
    endcase
    mask_in = {4'b0000, base_strb} << off;
    lane_be = '0;
    for (int unsigned i = 0; i < 8; i++) lane_be[8*i +: 8] = {8{mask_in[i]}};
    data_in = ({32'b0, store_data} << {off, 3'b000}) & lane_be;
  end

`ifdef MISALIGN_SPLIT_EN
  logic cross;
  assign misal  = 1'b0;
  assign second = (state_q == ACCESS2);
  assign cross  = |mask_q[7:4];
`else
  assign misal  = ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
  assign second = 1'b0;
`endif

  assign timeout_hit = (WAIT_LIMIT != 0) && !mem_ready && (wait_cnt == WAIT_LIMIT - 1);
  assign merged      = second ? {mem_rdata, rdata_lo_q} : {32'b0, mem_rdata};

  function automatic logic [31:0] extend(input logic [63:0] m, input logic [1:0] off_v,
                                         input logic [1:0] size_v, input logic uns);
    logic [31:0] raw;
    raw = 32'(m >> {off_v, 3'b000});
    case (size_v)
      2'd0:    extend = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    extend = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (legal && !misal) ? ACCESS : RESP;
`ifdef MISALIGN_SPLIT_EN
      ACCESS:  if (mem_ready) state_d = cross ? ACCESS2 : RESP;
               else if (timeout_hit) state_d = RESP;
      ACCESS2: if (mem_ready || timeout_hit) state_d = RESP;
`else
      ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      mis_q        <= 1'b0;
      to_q         <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      word_addr_q  <= '0;
      rdata_lo_q   <= '0;
      load_value_q <= '0;
      wait_cnt     <= '0;
      mask_q       <= '0;
      data_q       <= '0;
    end else begin
      mis_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          we_q        <= is_store;
          uns_q       <= funct3[2];
          size_q      <= size;
          off_q       <= off;
          word_addr_q <= {address[31:2], 2'b00};
          mask_q      <= mask_in;
          data_q      <= is_store ? data_in : '0;
          wait_cnt    <= '0;
          if (!legal || misal) begin
            load_value_q <= '0;
            mis_q        <= legal;
          end
        end
        RESP: ;
        default: begin
          if (mem_ready) begin
            rdata_lo_q   <= mem_rdata;
            wait_cnt     <= '0;
            load_value_q <= we_q ? '0 : extend(merged, off_q, size_q, uns_q);
          end else if (timeout_hit) begin
            to_q         <= 1'b1;
            load_value_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == RESP);
  assign mem_req     = (state_q == ACCESS) || second;
  assign mem_we      = we_q && mem_req;
  assign mem_addr    = word_addr_q + (second ? 32'd4 : 32'd0);
  assign mem_wdata   = second ? data_q[63:32] : data_q[31:0];
  assign mem_wstrb   = mem_we ? (second ? mask_q[7:4] : mask_q[3:0]) : 4'b0000;
  assign load_value  = load_value_q;
  assign misaligned  = mis_q;
  assign bus_timeout = to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected results queued at start, compared at done.
module tb_load_store_unit;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, mem_rdata;
  logic        busy, done, misaligned, bus_timeout, mem_req, mem_we;
  logic [31:0] load_value, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] lv; logic mis; logic to; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];

  typedef struct packed { logic [2:0] f3; logic [31:0] a; logic [31:0] rd; logic [31:0] ex; } ld_row_t;
  typedef struct packed { logic [2:0] f3; logic [31:0] a; logic [31:0] d; logic [3:0] strb; logic [31:0] wd; } st_row_t;
  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic [31:0] a; logic mis; } rj_row_t;

  localparam ld_row_t LD_ROWS [8] = '{
    '{3'd0, 32'h103, 32'h80112233, 32'hFFFFFF80},
    '{3'd4, 32'h103, 32'h80112233, 32'h00000080},
    '{3'd1, 32'h102, 32'h80017FFF, 32'hFFFF8001},
    '{3'd5, 32'h102, 32'h80017FFF, 32'h00008001},
    '{3'd1, 32'h100, 32'h80017FFF, 32'h00007FFF},
    '{3'd0, 32'h101, 32'h0000F500, 32'hFFFFFFF5},
    '{3'd4, 32'h100, 32'h123456A7, 32'h000000A7},
    '{3'd2, 32'h10C, 32'h01234567, 32'h01234567}
  };

  localparam st_row_t ST_ROWS [6] = '{
    '{3'd1, 32'h202, 32'h0000ABCD, 4'b1100, 32'hABCD0000},
    '{3'd0, 32'h201, 32'hFFFFFF5A, 4'b0010, 32'h00005A00},
    '{3'd0, 32'h203, 32'h12345678, 4'b1000, 32'h78000000},
    '{3'd2, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D},
    '{3'd1, 32'h200, 32'hFFFF1234, 4'b0011, 32'h00001234},
    '{3'd0, 32'h200, 32'hAAAAAA81, 4'b0001, 32'h00000081}
  };

  localparam rj_row_t RJ_ROWS [8] = '{
    '{OP_L, 3'd2, 32'h101, 1'b1},
    '{OP_L, 3'd1, 32'h103, 1'b1},
    '{OP_S, 3'd2, 32'h102, 1'b1},
    '{OP_S, 3'd1, 32'h201, 1'b1},
    '{OP_L, 3'd3, 32'h100, 1'b0},
    '{OP_S, 3'd4, 32'h100, 1'b0},
    '{7'b0110011, 3'd0, 32'h100, 1'b0},
    '{OP_L, 3'd6, 32'h100, 1'b0}
  };

  int          cyc, req_cycles, unstable;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_strb;

  always #5 clk = ~clk;

  load_store_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done),
    .load_value(load_value), .misaligned(misaligned), .bus_timeout(bus_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Drives start for one edge; returns at the negedge one cycle after the start edge.
  task automatic start_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    op_code = op; funct3 = f3; address = a; store_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_code = 7'($urandom); funct3 = 3'($urandom);
    address = $urandom; store_data = $urandom;
  endtask

  // Bus responder: each transaction waits 'waits' cycles, then returns the next rd_q word.
  task automatic serve(input int waits);
    int   w;
    logic prev_req;
    w = 0; cyc = 1; req_cycles = 0; unstable = 0; prev_req = 1'b0;
    while (!done && cyc < 40) begin
      if (mem_req) begin
        if (prev_req && (mem_addr !== cap_addr || mem_we !== cap_we ||
                         mem_wstrb !== cap_strb || mem_wdata !== cap_wdata)) unstable++;
        if (!prev_req) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_strb = mem_wstrb; cap_wdata = mem_wdata;
        end
        req_cycles++;
        if (w >= waits) begin
          mem_ready = 1'b1;
          if (rd_q.size() != 0) mem_rdata = rd_q.pop_front();
          else mem_rdata = $urandom;
          w = 0; prev_req = 1'b0;
        end else begin
          mem_ready = 1'b0; w++; prev_req = 1'b1;
        end
      end else begin
        prev_req = 1'b0;
      end
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0; mem_rdata = $urandom;
    end
    rd_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    op_code = '0; funct3 = '0; address = '0; store_data = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, misaligned, bus_timeout, mem_req, mem_we, mem_wstrb} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, misaligned, bus_timeout, mem_req, mem_we, mem_wstrb});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, load_value} !== 96'b0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, load_value});
    end
    rst = 1'b0;
  endtask

  task automatic test_lw_wait();
    exp_t e;
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
    start_op(OP_L, 3'd2, 32'h100, 32'h0);
    n_checks++; if ({busy, mem_req} !== 2'b11) begin n_fail++; $display("FAIL lw_req_latency: got %b want 11", {busy, mem_req}); end
    rd_q.push_back(32'hDEADBEEF);
    serve(3);
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b want 1", done); end
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL lw_latency: got %0d want 5", cyc); end
    n_checks++; if (cap_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", cap_addr); end
    n_checks++; if ({cap_we, cap_strb} !== 5'b0) begin n_fail++; $display("FAIL lw_we_strb: got %b want 0", {cap_we, cap_strb}); end
    n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL lw_value: got %h want %h", load_value, e.lv); end
    n_checks++; if ({misaligned, bus_timeout} !== {e.mis, e.to}) begin n_fail++; $display("FAIL lw_flags: got %b want %b", {misaligned, bus_timeout}, {e.mis, e.to}); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL lw_stable: got %0d want 0", unstable); end
    @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL lw_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    start_op(OP_L, 3'd2, 32'h600, 32'h0);
    serve(100);
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b want 1", done); end
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL to_latency: got %0d want 5", cyc); end
    n_checks++; if ({misaligned, bus_timeout, mem_req} !== {e.mis, e.to, 1'b0}) begin n_fail++; $display("FAIL to_flags: got %b want %b", {misaligned, bus_timeout, mem_req}, {e.mis, e.to, 1'b0}); end
    n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL to_value: got %h want %h", load_value, e.lv); end
    @(negedge clk);
    n_checks++; if ({busy, bus_timeout} !== 2'b00) begin n_fail++; $display("FAIL to_flag_clear: got %b want 00", {busy, bus_timeout}); end
  endtask

  task automatic test_stores();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{32'h0, 1'b0, 1'b0});
      start_op(OP_S, ST_ROWS[i].f3, ST_ROWS[i].a, ST_ROWS[i].d);
      serve(i % 2);
      e = exp_q.pop_front();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL st%0d_done: got %b want 1", i, done); end
      n_checks++; if (cap_we !== 1'b1) begin n_fail++; $display("FAIL st%0d_we: got %b want 1", i, cap_we); end
      n_checks++; if (cap_addr !== (ST_ROWS[i].a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL st%0d_addr: got %h want %h", i, cap_addr, ST_ROWS[i].a & 32'hFFFF_FFFC); end
      n_checks++; if (cap_strb !== ST_ROWS[i].strb) begin n_fail++; $display("FAIL st%0d_strb: got %b want %b", i, cap_strb, ST_ROWS[i].strb); end
      n_checks++; if (cap_wdata !== ST_ROWS[i].wd) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, cap_wdata, ST_ROWS[i].wd); end
      n_checks++; if ({misaligned, bus_timeout} !== {e.mis, e.to}) begin n_fail++; $display("FAIL st%0d_flags: got %b want %b", i, {misaligned, bus_timeout}, {e.mis, e.to}); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL st%0d_stable: got %0d want 0", i, unstable); end
    end
  endtask

  task automatic test_loads();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{LD_ROWS[i].ex, 1'b0, 1'b0});
      start_op(OP_L, LD_ROWS[i].f3, LD_ROWS[i].a, 32'hFFFFFFFF);
      rd_q.push_back(LD_ROWS[i].rd);
      serve(i % 3);
      e = exp_q.pop_front();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ld%0d_done: got %b want 1", i, done); end
      n_checks++; if (cyc != 2 + i % 3) begin n_fail++; $display("FAIL ld%0d_latency: got %0d want %0d", i, cyc, 2 + i % 3); end
      n_checks++; if (cap_addr !== (LD_ROWS[i].a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL ld%0d_addr: got %h want %h", i, cap_addr, LD_ROWS[i].a & 32'hFFFF_FFFC); end
      n_checks++; if ({cap_we, cap_strb} !== 5'b0) begin n_fail++; $display("FAIL ld%0d_we_strb: got %b want 0", i, {cap_we, cap_strb}); end
      n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL ld%0d_value: got %h want %h", i, load_value, e.lv); end
      n_checks++; if ({misaligned, bus_timeout} !== {e.mis, e.to}) begin n_fail++; $display("FAIL ld%0d_flags: got %b want %b", i, {misaligned, bus_timeout}, {e.mis, e.to}); end
    end
  endtask

  task automatic test_reject();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
`ifdef MISALIGN_SPLIT_EN
      if (RJ_ROWS[i].mis) continue;
`endif
      exp_q.push_back('{32'h0, RJ_ROWS[i].mis, 1'b0});
      start_op(RJ_ROWS[i].op, RJ_ROWS[i].f3, RJ_ROWS[i].a, 32'hFFFFFFFF);
      serve(0);
      e = exp_q.pop_front();
      n_checks++; if (done !== 1'b1 || cyc != 1) begin n_fail++; $display("FAIL rj%0d_done: got done=%b cyc=%0d want done=1 cyc=1", i, done, cyc); end
      n_checks++; if (req_cycles != 0) begin n_fail++; $display("FAIL rj%0d_no_req: got %0d want 0", i, req_cycles); end
      n_checks++; if ({misaligned, bus_timeout} !== {e.mis, e.to}) begin n_fail++; $display("FAIL rj%0d_flags: got %b want %b", i, {misaligned, bus_timeout}, {e.mis, e.to}); end
      n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL rj%0d_value: got %h want %h", i, load_value, e.lv); end
    end
`ifdef MISALIGN_SPLIT_EN
    exp_q.push_back('{32'h55443322, 1'b0, 1'b0});
    start_op(OP_L, 3'd2, 32'h101, 32'h0);
    rd_q.push_back(32'h44332211);
    rd_q.push_back(32'h88776655);
    serve(1);
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL split_done: got %b want 1", done); end
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL split_req_cycles: got %0d want 4", req_cycles); end
    n_checks++; if (cap_addr !== 32'h104) begin n_fail++; $display("FAIL split_addr2: got %h want 00000104", cap_addr); end
    n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL split_value: got %h want %h", load_value, e.lv); end
    n_checks++; if ({misaligned, bus_timeout} !== {e.mis, e.to}) begin n_fail++; $display("FAIL split_flags: got %b want %b", {misaligned, bus_timeout}, {e.mis, e.to}); end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_q.push_back('{32'h11223344, 1'b0, 1'b0});
    start_op(OP_L, 3'd2, 32'h300, 32'h0);
    start = 1'b1; op_code = OP_S; funct3 = 3'd2; address = 32'h400; store_data = 32'hFFFFFFFF;
    rd_q.push_back(32'h11223344);
    serve(2);
    start = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    n_checks++; if ({cap_addr, cap_we} !== {32'h300, 1'b0}) begin n_fail++; $display("FAIL b2b_addr_we: got %h/%b want 00000300/0", cap_addr, cap_we); end
    n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL b2b_value: got %h want %h", load_value, e.lv); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL b2b_stable: got %0d want 0", unstable); end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    n_checks++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL b2b_not_queued: got %b want 00", {busy, mem_req}); end
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    start_op(OP_S, 3'd0, 32'h406, 32'h000000C3);
    serve(0);
    e = exp_q.pop_front();
    n_checks++; if ({done, cap_we, cap_strb} !== 6'b11_0100) begin n_fail++; $display("FAIL b2b_sb_strb: got %b want 110100", {done, cap_we, cap_strb}); end
    n_checks++; if ({cap_addr, cap_wdata} !== {32'h404, 32'h00C30000}) begin n_fail++; $display("FAIL b2b_sb_data: got %h/%h want 00000404/00c30000", cap_addr, cap_wdata); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    start_op(OP_L, 3'd2, 32'h500, 32'h0);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_drop: got %b want 00", {mem_req, busy}); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{32'h5A5A0F0F, 1'b0, 1'b0});
    start_op(OP_L, 3'd2, 32'h504, 32'h0);
    rd_q.push_back(32'h5A5A0F0F);
    serve(0);
    e = exp_q.pop_front();
    n_checks++; if ({done, cap_addr} !== {1'b1, 32'h504}) begin n_fail++; $display("FAIL rstmid_next: got %b/%h want 1/00000504", done, cap_addr); end
    n_checks++; if (load_value !== e.lv) begin n_fail++; $display("FAIL rstmid_value: got %h want %h", load_value, e.lv); end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_timeout();
    test_stores();
    test_loads();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
